// File: rtl/rp_share_arb.sv
// rtl/rp_share_arb.sv - round-robin sharing of one reconfigurable-partition arithmetic unit
//
// Purpose: arbitrates NREQ requesters onto a single RP arithmetic unit with a
// registered, fixed-latency result. One operation is in flight at a time; the
// result is returned to the granted requester and held until it is accepted.
// The PR decouple input blocks new issues and poisons an op in flight.
//
// Ports:
//   Clk, Reset_n            clock, synchronous active-low reset
//   req_valid/req_a/req_b   per-requester operand pairs (requester i at [i*DW +: DW])
//   req_ready               one-hot accept strobe (combinational, IDLE only)
//   rsp_valid/rsp_data      one-hot response valid and its result
//   rsp_err                 response invalid because the RP was decoupled mid-op
//   rsp_ready               per-requester response accept
//   rp_ain/rp_bin           registered RP operands
//   rp_result               RP result
//   rp_decouple             PR controller isolating the RP
//   rp_idle                 no operation in flight
module rp_share_arb #(
  parameter int NREQ       = 4,
  parameter int DW         = 32,
  parameter int RP_LATENCY = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_data,
  output logic              rsp_err,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [DW-1:0]     rp_ain,
  output logic [DW-1:0]     rp_bin,
  input  logic [DW-1:0]     rp_result,
  input  logic              rp_decouple,
  output logic              rp_idle
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gnt;
  logic [2:0]      cnt;
  logic            err;

  logic [PW-1:0]   sel;
  logic            sel_found;
  logic            grant_en;
  logic            err_next;
  int              idx;

  // Circular search starting just after the last grant, so the most recent
  // winner drops to lowest priority.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    idx       = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!sel_found && req_valid[idx[PW-1:0]]) begin
        sel_found = 1'b1;
        sel       = idx[PW-1:0];
      end
    end
  end

  // Reset_n gating keeps the strobe low while reset is held.
  assign grant_en  = Reset_n && (state == S_IDLE) && sel_found && !rp_decouple;
  assign req_ready = grant_en ? (ONE << sel) : '0;

  // Includes this cycle's decouple so a pulse on the capture cycle still poisons the result.
  assign err_next  = err | rp_decouple;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      rr_ptr    <= PW'(NREQ - 1);
      gnt       <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rp_ain    <= '0;
      rp_bin    <= '0;
      rp_idle   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_en) begin
            rp_ain  <= req_a[int'(sel)*DW +: DW];
            rp_bin  <= req_b[int'(sel)*DW +: DW];
            gnt     <= sel;
            rr_ptr  <= sel;
            cnt     <= 3'(RP_LATENCY);
            err     <= 1'b0;
            rp_idle <= 1'b0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          err <= err_next;
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            rsp_data  <= err_next ? '0 : rp_result;
            rsp_err   <= err_next;
            rsp_valid <= ONE << gnt;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          // Only the granted requester's accept matters.
          if (rsp_ready[gnt]) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            rp_idle   <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state   <= S_IDLE;
          rp_idle <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rp_share_arb.sv
// tb/tb_rp_share_arb.sv - scenario bench for rp_share_arb
module tb_rp_share_arb;

  localparam int NREQ = 4;
  localparam int DW   = 32;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              rsp_err;
  logic [NREQ-1:0]   rsp_ready;
  logic [DW-1:0]     rp_ain;
  logic [DW-1:0]     rp_bin;
  logic [DW-1:0]     rp_result;
  logic              rp_decouple;
  logic              rp_idle;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  // RP stand-in: an adder with a single output register (latency 1).
  always_ff @(posedge Clk) rp_result <= rp_ain + rp_bin;

  rp_share_arb #(.NREQ(NREQ), .DW(DW), .RP_LATENCY(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .rp_ain(rp_ain), .rp_bin(rp_bin), .rp_result(rp_result),
    .rp_decouple(rp_decouple), .rp_idle(rp_idle)
  );

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0; req_valid = '0; rsp_ready = '0; rp_decouple = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    sb.delete();
  endtask

  // Waits (bounded) for any rsp_valid; n = cycles waited, -1 on timeout.
  task automatic wait_rsp(output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk); #1;
      if (n < 0 && |rsp_valid) n = k;
      if (n >= 0) k = 41;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    @(negedge Clk);
    Reset_n = 1'b0; req_valid = 4'b1111; rsp_ready = '0; rp_decouple = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    vectors++;
    if (req_ready !== 4'b0 || rsp_valid !== 4'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0 ||
        rp_ain !== 32'h0 || rp_bin !== 32'h0 || rp_idle !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%b vld=%b data=%h err=%b ain=%h bin=%h idle=%b, want 0 0 0 0 0 0 1",
               req_ready, rsp_valid, rsp_data, rsp_err, rp_ain, rp_bin, rp_idle);
    end
    req_valid = '0;
    Reset_n = 1'b1;
    sb.delete();
  endtask

  task automatic test_single();
    exp_t e;
    int n;
    @(negedge Clk);
    set_ops(0, 32'd5, 32'd7);
    req_valid = 4'b0001; rsp_ready = 4'b0001;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    sb.push_back('{idx: 0, data: 32'd12, err: 1'b0});
    wait_rsp(n);
    req_valid = '0;
    vectors++;
    if (n !== 3) begin
      miscompares++;
      $display("FAIL single_latency: got %0d cycles want 3", n);
    end
    if (n > 0 && sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (rsp_valid !== oh(e.idx) || rsp_data !== e.data || rsp_err !== e.err) begin
        miscompares++;
        $display("FAIL single_rsp: got vld=%b data=%h err=%b want vld=%b data=%h err=%b",
                 rsp_valid, rsp_data, rsp_err, oh(e.idx), e.data, e.err);
      end
    end
    @(negedge Clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int gcyc[$];
    int gidx[$];
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'(100 * i + 1), 32'(i + 3));
    req_valid = 4'b1111; rsp_ready = 4'b1111;
    for (int c = 0; c < 24; c++) begin
      #1;
      vectors++;
      if (!$onehot0(req_ready)) begin
        miscompares++;
        $display("FAIL rr_onehot: cycle %0d req_ready=%b want at most one bit", c, req_ready);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          gcyc.push_back(c); gidx.push_back(i);
          sb.push_back('{idx: i, data: 32'(100 * i + 1) + 32'(i + 3), err: 1'b0});
        end
      end
      if (|rsp_valid) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL rr_rsp: unexpected response vld=%b, want none", rsp_valid);
        end else begin
          e = sb.pop_front();
          if (rsp_valid !== oh(e.idx) || rsp_data !== e.data || rsp_err !== e.err) begin
            miscompares++;
            $display("FAIL rr_rsp: got vld=%b data=%h err=%b want vld=%b data=%h err=%b",
                     rsp_valid, rsp_data, rsp_err, oh(e.idx), e.data, e.err);
          end
        end
      end
      if (c == 23) req_valid = '0;
      @(negedge Clk);
    end
    vectors++;
    if (gidx.size() != 6) begin
      miscompares++;
      $display("FAIL rr_count: got %0d grants want 6", gidx.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        vectors++;
        if (gidx[k] != exp_order[k] || gcyc[k] != 4 * k) begin
          miscompares++;
          $display("FAIL rr_grant%0d: got req %0d at cycle %0d want req %0d at cycle %0d",
                   k, gidx[k], gcyc[k], exp_order[k], 4 * k);
        end
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    int n;
    @(negedge Clk);
    set_ops(2, 32'hFFFF_FFFF, 32'd2);
    req_valid = 4'b0100; rsp_ready = 4'b0100;
    #1;
    vectors++;
    if (req_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL wrap_ready: got %b want 0100", req_ready);
    end
    sb.push_back('{idx: 2, data: 32'h0000_0001, err: 1'b0});
    wait_rsp(n);
    req_valid = '0;
    vectors++;
    if (n < 0 || sb.size() == 0) begin
      miscompares++;
      $display("FAIL wrap_rsp: got no response want data 00000001");
    end else begin
      e = sb.pop_front();
      if (rsp_valid !== oh(e.idx) || rsp_data !== e.data || rsp_err !== e.err) begin
        miscompares++;
        $display("FAIL wrap_rsp: got vld=%b data=%h err=%b want vld=%b data=%h err=%b",
                 rsp_valid, rsp_data, rsp_err, oh(e.idx), e.data, e.err);
      end
    end
    @(negedge Clk);
  endtask

  task automatic test_backpressure();
    exp_t e;
    int n;
    @(negedge Clk);
    set_ops(3, 32'd100, 32'd23);
    set_ops(0, 32'd9, 32'd9);
    req_valid = 4'b1000; rsp_ready = 4'b0111;
    #1;
    vectors++;
    if (req_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL bp_ready: got %b want 1000", req_ready);
    end
    sb.push_back('{idx: 3, data: 32'd123, err: 1'b0});
    @(negedge Clk);
    req_valid = 4'b0001;
    wait_rsp(n);
    vectors++;
    if (n < 0 || sb.size() == 0) begin
      miscompares++;
      $display("FAIL bp_rsp: got no response want data 123");
    end else begin
      e = sb.pop_front();
      if (rsp_valid !== oh(e.idx) || rsp_data !== e.data || rsp_err !== e.err) begin
        miscompares++;
        $display("FAIL bp_rsp: got vld=%b data=%h err=%b want vld=%b data=%h err=%b",
                 rsp_valid, rsp_data, rsp_err, oh(e.idx), e.data, e.err);
      end
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk); #1;
      vectors++;
      if (rsp_valid !== 4'b1000 || rsp_data !== 32'd123 || req_ready !== 4'b0 || rp_idle !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got vld=%b data=%0d rdy=%b idle=%b want 1000 123 0000 0",
                 c, rsp_valid, rsp_data, req_ready, rp_idle);
      end
    end
    rsp_ready = 4'b1000; req_valid = '0;
    @(negedge Clk); #1;
    vectors++;
    if (rp_idle !== 1'b1 || rsp_valid !== 4'b0 || rsp_data !== 32'h0) begin
      miscompares++;
      $display("FAIL bp_release: got idle=%b vld=%b data=%h want 1 0000 0", rp_idle, rsp_valid, rsp_data);
    end
  endtask

  task automatic test_decouple();
    exp_t e;
    int n;
    @(negedge Clk);
    set_ops(1, 32'd3, 32'd4);
    rp_decouple = 1'b1; req_valid = 4'b0010; rsp_ready = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (req_ready !== 4'b0 || rp_idle !== 1'b1) begin
        miscompares++;
        $display("FAIL dec_block%0d: got rdy=%b idle=%b want 0000 1", c, req_ready, rp_idle);
      end
      @(negedge Clk);
    end
    rp_decouple = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL dec_accept: got %b want 0010", req_ready);
    end
    sb.push_back('{idx: 1, data: 32'h0, err: 1'b1});
    @(negedge Clk);
    req_valid = '0; rp_decouple = 1'b1;
    @(negedge Clk);
    rp_decouple = 1'b0;
    wait_rsp(n);
    vectors++;
    if (n < 0 || sb.size() == 0) begin
      miscompares++;
      $display("FAIL dec_rsp: got no response want err=1");
    end else begin
      e = sb.pop_front();
      if (rsp_valid !== oh(e.idx) || rsp_data !== e.data || rsp_err !== e.err) begin
        miscompares++;
        $display("FAIL dec_rsp: got vld=%b data=%h err=%b want vld=%b data=%h err=%b",
                 rsp_valid, rsp_data, rsp_err, oh(e.idx), e.data, e.err);
      end
    end
    @(negedge Clk); #1;
    vectors++;
    if (rsp_err !== 1'b0 || rsp_valid !== 4'b0) begin
      miscompares++;
      $display("FAIL dec_clear: got err=%b vld=%b want 0 0000", rsp_err, rsp_valid);
    end
  endtask

  task automatic test_reset_midop();
    exp_t e;
    int n;
    logic seen;
    @(negedge Clk);
    set_ops(2, 32'd1, 32'd1);
    req_valid = 4'b0100; rsp_ready = 4'b1111;
    #1;
    vectors++;
    if (req_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL rst_mid_accept: got %b want 0100", req_ready);
    end
    @(negedge Clk);
    Reset_n = 1'b0; req_valid = '0;
    sb.delete();
    @(negedge Clk); #1;
    vectors++;
    if (req_ready !== 4'b0 || rsp_valid !== 4'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0 ||
        rp_ain !== 32'h0 || rp_bin !== 32'h0 || rp_idle !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_state: got rdy=%b vld=%b data=%h err=%b ain=%h bin=%h idle=%b, want 0 0 0 0 0 0 1",
               req_ready, rsp_valid, rsp_data, rsp_err, rp_ain, rp_bin, rp_idle);
    end
    Reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk); #1;
      if (|rsp_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_dropped: got response for dropped op, want none");
    end
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'(i + 20), 32'(i * 2));
    req_valid = 4'b1111;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL rst_mid_prio: got %b want 0001", req_ready);
    end
    sb.push_back('{idx: 0, data: 32'd20, err: 1'b0});
    @(negedge Clk);
    req_valid = '0;
    wait_rsp(n);
    vectors++;
    if (n < 0 || sb.size() == 0) begin
      miscompares++;
      $display("FAIL rst_mid_rsp: got no response want data 20");
    end else begin
      e = sb.pop_front();
      if (rsp_valid !== oh(e.idx) || rsp_data !== e.data || rsp_err !== e.err) begin
        miscompares++;
        $display("FAIL rst_mid_rsp: got vld=%b data=%h err=%b want vld=%b data=%h err=%b",
                 rsp_valid, rsp_data, rsp_err, oh(e.idx), e.data, e.err);
      end
    end
    @(negedge Clk);
  endtask

  initial begin
    Reset_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    rsp_ready = '0; rp_decouple = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_backpressure();
    test_decouple();
    test_reset_midop();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_empty: got %0d outstanding want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
